vram_writer: RTL and testbench
==============================

VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 SHALL have no parameters; FIFO depth is fixed at 4 entries.
REQ-002 clk_sys  in  1  master clock; all logic on posedge.
REQ-003 nRESET  in  1  synchronous reset, active-low, sampled on posedge clk_sys.
REQ-004 addr  in  16  CPU address bus.
REQ-005 din  in  8  CPU data bus.
REQ-006 nMREQ, nWR, nRFSH  in  1 each  CPU strobes, active-low.
REQ-007 m128  in  1  128K paging enabled.
REQ-008 page_ram  in  3  RAM bank mapped at 0xC000.
REQ-009 enable  in  1  snoop enable; when 0, no new captures occur and the FIFO continues to drain.
REQ-010 vram_we  out  1  write request to the VRAM write port; high while the FIFO is non-empty.
REQ-011 vram_waddr  out  15  VRAM address; bit14 = 0 selects bank 5, bit14 = 1 selects bank 7; bits 13:0 are the offset.
REQ-012 vram_wdata  out  8  VRAM write data.
REQ-013 vram_wready  in  1  VRAM port accepts the presented entry this cycle.
REQ-014 level  out  3  FIFO occupancy, 0..4.
REQ-015 overflow  out  1  sticky flag; set when a capture is dropped.
REQ-016 ovf_clr  in  1  clears overflow.

Function
REQ-017 The strobe wr = ~nMREQ & ~nWR & nRFSH SHALL be registered once; a capture event is a cycle with wr=1 and wr_q=0 and enable=1.
REQ-018 A write held over many cycles SHALL produce exactly one capture event.
REQ-019 Decode SHALL use addr, din, m128 and page_ram sampled in the capture-event cycle.
- addr[15:14]=01 -> bank 5.
- addr[15:14]=11 with m128=1 and page_ram=5 -> bank 5.
- addr[15:14]=11 with m128=1 and page_ram=7 -> bank 7.
- All other cases are ignored.
REQ-020 A pushed entry SHALL be {bank7, addr[13:0], din}.
REQ-021 The FIFO SHALL be first-in first-out and 4 deep, with read and write pointers wrapping modulo 4.
REQ-022 Outputs SHALL present the head entry; vram_we=1 whenever level>0.
REQ-023 Pop SHALL occur in a cycle where vram_we=1 and vram_wready=1; the next entry (if any) SHALL appear on the following cycle.
REQ-024 Latency: a capture event in cycle N into an empty FIFO SHALL give vram_we=1 with that entry at cycle N+1.
REQ-025 Push and pop in the same cycle SHALL both occur and leave level unchanged, including when level=4.
REQ-026 A push at level=4 with no pop in the same cycle SHALL be dropped; overflow SHALL be set at the next cycle and FIFO contents SHALL be unchanged.
REQ-027 overflow SHALL hold until ovf_clr=1; if ovf_clr and a new drop coincide, overflow SHALL remain 1.
REQ-028 At level=0, vram_wready SHALL be ignored; pointers SHALL not move and level SHALL not underflow.
REQ-029 Outputs SHALL not change while vram_we=1 and vram_wready=0 (stall holds the entry stable).
REQ-030 level SHALL equal the pushes minus pops since reset, and SHALL never exceed 4.

Reset
REQ-031 With nRESET=0 at a posedge: FIFO emptied, pointers=0, level=0, vram_we=0, overflow=0, wr_q=0; vram_waddr and vram_wdata=0.
REQ-032 No capture SHALL occur in a cycle where nRESET=0.
REQ-033 A write strobe already low when reset releases SHALL be captured once, on the first cycle after release.
REQ-034 Reset mid-drain SHALL discard all pending entries; no further vram_we until a new capture.

Verification
REQ-035 Write 0x4000<=0xAA, wready=1 -> one cycle vram_we=1, waddr=0x0000, wdata=0xAA; level returns to 0.
REQ-036 m128=1, page_ram=7, write 0xDAFF<=0x55 -> waddr=0x5AFF; repeat with page_ram=3 -> no vram_we.
REQ-037 wready=0, five writes to 0x4001..0x4005 -> level=4, overflow=1; raise wready -> data for 0x0001..0x0004 drained in order; 0x4005 absent.
REQ-038 level=4 and wready=1, capture coincides with pop -> level stays 4, overflow stays 0.
REQ-039 Write strobe held low for 10 cycles -> exactly one entry; nRFSH=0 during the strobe -> no entry.
REQ-040 Two entries queued, nRESET=0 for one cycle -> vram_we=0 and level=0 the next cycle; overflow cleared.

Source files
------------

// File: rtl/vram_writer.sv
// Snoops CPU memory writes that land in the video banks (5 and 7) and queues
// them in a 4-entry FIFO that drains into a dedicated VRAM write port.
module vram_writer (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        nMREQ,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic        m128,
  input  logic [2:0]  page_ram,
  input  logic        enable,
  output logic        vram_we,
  output logic [14:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  input  logic        vram_wready,
  output logic [2:0]  level,
  output logic        overflow,
  input  logic        ovf_clr
);

  logic        wr;
  logic        wr_q;
  logic        capture;
  logic        hit;
  logic        bank7;
  logic [22:0] entry;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;
  logic        drop;

  logic [22:0] mem_q [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  level_q, level_d;
  logic        ovf_q, ovf_d;
  logic [22:0] head;

  assign wr      = ~nMREQ & ~nWR & nRFSH;
  assign capture = wr & ~wr_q & enable;

  // Bank 5 is always visible at 0x4000; 0xC000 only maps video RAM in 128K mode.
  assign bank7 = (addr[15:14] == 2'b11) & m128 & (page_ram == 3'd7);
  assign hit   = (addr[15:14] == 2'b01) |
                 ((addr[15:14] == 2'b11) & m128 & ((page_ram == 3'd5) | (page_ram == 3'd7)));
  assign entry = {bank7, addr[13:0], din};

  assign push_req = capture & hit;
  assign full     = (level_q == 3'd4);
  assign pop      = (level_q != 3'd0) & vram_wready;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    if (push) wr_ptr_d = wr_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
    // A new drop wins over a simultaneous clear so no loss goes unreported.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      wr_q     <= 1'b0;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      level_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_q     <= wr;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
          mem_q[gi] <= '0;
        end else if (push && (wr_ptr_q == 2'(gi))) begin
          mem_q[gi] <= entry;
        end
      end
    end
  endgenerate

  // Address/data read as zero whenever nothing is being offered.
  assign head       = mem_q[rd_ptr_q];
  assign vram_we    = (level_q != 3'd0);
  assign vram_waddr = vram_we ? head[22:8] : 15'd0;
  assign vram_wdata = vram_we ? head[7:0]  : 8'd0;
  assign level      = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_vram_writer;

  logic        clk_sys = 1'b0;
  logic        nRESET;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nMREQ, nWR, nRFSH;
  logic        m128;
  logic [2:0]  page_ram;
  logic        enable;
  logic        vram_we;
  logic [14:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_wready;
  logic [2:0]  level;
  logic        overflow;
  logic        ovf_clr;

  int n_pass  = 0;
  int n_total = 0;

  vram_writer dut (
    .clk_sys     (clk_sys),
    .nRESET      (nRESET),
    .addr        (addr),
    .din         (din),
    .nMREQ       (nMREQ),
    .nWR         (nWR),
    .nRFSH       (nRFSH),
    .m128        (m128),
    .page_ram    (page_ram),
    .enable      (enable),
    .vram_we     (vram_we),
    .vram_waddr  (vram_waddr),
    .vram_wdata  (vram_wdata),
    .vram_wready (vram_wready),
    .level       (level),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: a plain queue of {waddr, wdata} pairs.
  int          mq_addr[$];
  int          mq_data[$];
  bit          m_wr_prev;
  bit          m_ovf;
  bit          model_valid = 0;

  initial forever begin
    @(posedge clk_sys);
    if (nRESET === 1'b0) begin
      mq_addr.delete();
      mq_data.delete();
      m_wr_prev   = 0;
      m_ovf       = 0;
      model_valid = 1;
    end else if (model_valid) begin
      bit wr, cap, is_vid, dropped;
      int vaddr;
      wr      = (nMREQ == 0) && (nWR == 0) && (nRFSH == 1);
      cap     = wr && !m_wr_prev && enable;
      is_vid  = 0;
      vaddr   = addr % 16384;
      dropped = 0;
      if (addr / 16384 == 1) is_vid = 1;
      else if (addr / 16384 == 3 && m128 && page_ram == 5) is_vid = 1;
      else if (addr / 16384 == 3 && m128 && page_ram == 7) begin
        is_vid = 1;
        vaddr  = vaddr + 16384;
      end
      if (mq_addr.size() > 0 && vram_wready) begin
        void'(mq_addr.pop_front());
        void'(mq_data.pop_front());
      end
      if (cap && is_vid) begin
        // Pop already applied above, so size 4 here means truly full.
        if (mq_addr.size() < 4) begin
          mq_addr.push_back(vaddr);
          mq_data.push_back(int'(din));
        end else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_wr_prev = wr;
    end
  end

  initial forever begin
    @(negedge clk_sys);
    if (model_valid) begin
      int n;
      n = mq_addr.size();
      chk("model_we",    32'(vram_we),    32'(n > 0));
      chk("model_level", 32'(level),      32'(n));
      chk("model_ovf",   32'(overflow),   32'(m_ovf));
      chk("model_waddr", 32'(vram_waddr), (n > 0) ? 32'(mq_addr[0]) : 32'd0);
      chk("model_wdata", 32'(vram_wdata), (n > 0) ? 32'(mq_data[0]) : 32'd0);
    end
  end

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0;
    step();
    nMREQ = 1'b1; nWR = 1'b1;
    step();
  endtask

  initial begin
    nRESET = 1'b0; addr = '0; din = '0; nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    m128 = 1'b0; page_ram = 3'd0; enable = 1'b1; vram_wready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    chk("rst_we", 32'(vram_we), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_waddr", 32'(vram_waddr), 0);
    chk("rst_wdata", 32'(vram_wdata), 0);
    nRESET = 1'b1;
    step();

    // Single write to 0x4000 drains in one cycle.
    vram_wready = 1'b1;
    addr = 16'h4000; din = 8'hAA; nMREQ = 1'b0; nWR = 1'b0;
    step();
    chk("w4000_we", 32'(vram_we), 1);
    chk("w4000_waddr", 32'(vram_waddr), 32'h0000);
    chk("w4000_wdata", 32'(vram_wdata), 32'hAA);
    nMREQ = 1'b1; nWR = 1'b1;
    step();
    chk("w4000_we_after", 32'(vram_we), 0);
    chk("w4000_level_after", 32'(level), 0);

    // Bank 7 via 0xC000 window, then an unmapped page.
    m128 = 1'b1; page_ram = 3'd7; vram_wready = 1'b0;
    strobe(16'hDAFF, 8'h55);
    chk("bank7_waddr", 32'(vram_waddr), 32'h5AFF);
    chk("bank7_wdata", 32'(vram_wdata), 32'h55);
    vram_wready = 1'b1;
    step();
    page_ram = 3'd3;
    strobe(16'hDAFF, 8'h55);
    chk("page3_we", 32'(vram_we), 0);

    // Overflow: five captures with the port stalled.
    vram_wready = 1'b0;
    for (int i = 1; i <= 5; i++) strobe(16'h4000 + 16'(i), 8'h10 + 8'(i));
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    vram_wready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_waddr", 32'(vram_waddr), 32'(i));
      chk("drain_wdata", 32'(vram_wdata), 32'h10 + 32'(i));
      step();
    end
    chk("drain_empty", 32'(vram_we), 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // Push and pop together while full.
    vram_wready = 1'b0;
    for (int i = 1; i <= 4; i++) strobe(16'h4000 + 16'(i), 8'h20 + 8'(i));
    vram_wready = 1'b1; addr = 16'h4006; din = 8'h26; nMREQ = 1'b0; nWR = 1'b0;
    step();
    chk("full_pushpop_level", 32'(level), 4);
    chk("full_pushpop_ovf", 32'(overflow), 0);
    chk("full_pushpop_head", 32'(vram_waddr), 32'h0002);
    nMREQ = 1'b1; nWR = 1'b1;
    repeat (4) step();
    chk("full_pushpop_drained", 32'(level), 0);

    // Long strobe yields one entry; refresh cycle yields none.
    vram_wready = 1'b0;
    addr = 16'h4100; din = 8'h33; nMREQ = 1'b0; nWR = 1'b0;
    repeat (10) step();
    nMREQ = 1'b1; nWR = 1'b1;
    step();
    chk("long_strobe_level", 32'(level), 1);
    vram_wready = 1'b1;
    step();
    nRFSH = 1'b0; nMREQ = 1'b0; nWR = 1'b0;
    step(); step();
    nRFSH = 1'b1; nMREQ = 1'b1; nWR = 1'b1;
    step();
    chk("rfsh_level", 32'(level), 0);

    // Snoop disabled.
    enable = 1'b0;
    strobe(16'h4300, 8'h44);
    chk("disabled_level", 32'(level), 0);
    enable = 1'b1;

    // Reset mid-queue discards entries and clears overflow.
    vram_wready = 1'b0;
    for (int i = 1; i <= 5; i++) strobe(16'h4010 + 16'(i), 8'h30 + 8'(i));
    chk("pre_rst_ovf", 32'(overflow), 1);
    nRESET = 1'b0;
    step();
    chk("midrst_we", 32'(vram_we), 0);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_ovf", 32'(overflow), 0);

    // Strobe already low across reset release is captured once.
    addr = 16'h4200; din = 8'h77; nMREQ = 1'b0; nWR = 1'b0;
    step();
    chk("strobe_in_rst_level", 32'(level), 0);
    nRESET = 1'b1;
    step();
    chk("rel_level", 32'(level), 1);
    chk("rel_waddr", 32'(vram_waddr), 32'h0200);
    chk("rel_wdata", 32'(vram_wdata), 32'h77);
    step(); step();
    chk("rel_once", 32'(level), 1);
    nMREQ = 1'b1; nWR = 1'b1; vram_wready = 1'b1;
    step();
    chk("rel_drained", 32'(level), 0);

    // Randomized phase, checked by the model process.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        nMREQ = ~nMREQ;
        nWR   = nMREQ ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        addr  = 16'($urandom);
        din   = 8'($urandom);
      end
      nRFSH       = 1'($urandom_range(0, 9) != 0);
      m128        = 1'($urandom_range(0, 3) != 0);
      page_ram    = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      enable      = 1'($urandom_range(0, 9) != 0);
      vram_wready = 1'($urandom_range(0, 2) == 0);
      ovf_clr     = 1'($urandom_range(0, 19) == 0);
      nRESET      = 1'($urandom_range(0, 299) != 0);
      step();
    end
    nRESET = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
